// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a combinational memory into a one-entry
// valid/ready output stage, and handles redirects. Optional FETCH_PERF_COUNT_EN adds fetch_count.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0]       fetch_count,
`endif
  output logic              fault
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] count_q, count_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
`ifdef FETCH_PERF_COUNT_EN
      count_q    <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
`ifdef FETCH_PERF_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    case (state_q)
      StRun: begin
        if (redirect) begin
          // A redirect voids any same-cycle handshake on the stage.
          valid_d = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            state_d = StFault;
          end
        end else if (!valid_q || instr_ready) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      StFault: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StFault;
        valid_d = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_COUNT_EN
  always_comb begin
    count_d = count_q;
    if (state_q == StRun && valid_q && instr_ready && !redirect) begin
      count_d = count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

  assign imem_addr   = pc_q[ADDR_W+1:2];
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fault       = (state_q == StFault);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, redirect, wrap, async reset, fault,
// and the optional FETCH_PERF_COUNT_EN counter.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count;
`endif

  logic [31:0] mem [4096];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .fault      (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;

    reset       = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #12;
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_addr", {20'b0, imem_addr}, 32'h0);
`ifdef FETCH_PERF_COUNT_EN
    chk("rst_count", fetch_count, 32'h0);
`endif

    // Streaming from reset.
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("c1_valid", {31'b0, instr_valid}, 32'h1);
    chk("c1_instr", instr, 32'h2008_0001);
    chk("c1_pc", instr_pc, 32'h0);
    tick();
    chk("c2_valid", {31'b0, instr_valid}, 32'h1);
    chk("c2_pc", instr_pc, 32'h4);
    chk("c2_instr", instr, 32'h2009_0002);

    // Stall three cycles while instr_pc=0x4.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", instr_pc, 32'h4);
      chk("stall_instr", instr, 32'h2009_0002);
      chk("stall_addr", {20'b0, imem_addr}, 32'd2);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
    end
    instr_ready = 1'b1;
    tick();
    chk("c3_pc", instr_pc, 32'h8);
    chk("c3_instr", instr, 32'h0109_5020);
    tick();
    chk("c4_pc", instr_pc, 32'hC);
    chk("c4_instr", instr, 32'h0);

    // Single-cycle redirect with a same-cycle handshake.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    chk("rd_bubble", {31'b0, instr_valid}, 32'h0);
    chk("rd_addr", {20'b0, imem_addr}, 32'd16);
    redirect = 1'b0;
    tick();
    chk("rd_valid", {31'b0, instr_valid}, 32'h1);
    chk("rd_pc", instr_pc, 32'h40);
    chk("rd_instr", instr, 32'hA000_0010);
    tick();
    chk("rd_next_pc", instr_pc, 32'h44);

    // Redirect held for two cycles.
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    tick();
    chk("hold_rd1", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("hold_rd2", {31'b0, instr_valid}, 32'h0);
    redirect = 1'b0;
    tick();
    chk("hold_pc", instr_pc, 32'h20);
    chk("hold_instr", instr, 32'hA000_0008);

    // Word-address wrap.
    redirect    = 1'b1;
    redirect_pc = 32'h3FF8;
    tick();
    chk("wrap_addr0", {20'b0, imem_addr}, 32'd4094);
    redirect = 1'b0;
    tick();
    chk("wrap_pc0", instr_pc, 32'h3FF8);
    chk("wrap_instr0", instr, 32'hA000_0FFE);
    chk("wrap_addr1", {20'b0, imem_addr}, 32'd4095);
    tick();
    chk("wrap_pc1", instr_pc, 32'h3FFC);
    chk("wrap_addr2", {20'b0, imem_addr}, 32'd0);
    tick();
    chk("wrap_pc2", instr_pc, 32'h4000);
    chk("wrap_instr2", instr, 32'h2008_0001);

    // Asynchronous reset mid-cycle, checked before any further edge.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc", instr_pc, 32'h0);
    chk("arst_addr", {20'b0, imem_addr}, 32'h0);
`ifdef FETCH_PERF_COUNT_EN
    chk("arst_count", fetch_count, 32'h0);
`endif

    // Ten retired handshakes around one redirect-voided handshake.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("perf_pc6", instr_pc, 32'h14);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    chk("perf_bubble", {31'b0, instr_valid}, 32'h0);
    redirect = 1'b0;
    tick();
    chk("perf_pc8", instr_pc, 32'h80);
    for (int i = 0; i < 5; i++) tick();
    chk("perf_pc13", instr_pc, 32'h94);
`ifdef FETCH_PERF_COUNT_EN
    chk("perf_count", fetch_count, 32'd10);
`endif

    // Misaligned redirect enters the sticky fault state.
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    tick();
    chk("flt_fault", {31'b0, fault}, 32'h1);
    chk("flt_valid", {31'b0, instr_valid}, 32'h0);
    chk("flt_addr", {20'b0, imem_addr}, 32'd38);
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    tick();
    chk("flt_sticky", {31'b0, fault}, 32'h1);
    chk("flt_valid2", {31'b0, instr_valid}, 32'h0);
    chk("flt_addr2", {20'b0, imem_addr}, 32'd38);
`ifdef FETCH_PERF_COUNT_EN
    chk("flt_count", fetch_count, 32'd10);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("flt_clear", {31'b0, fault}, 32'h0);
    chk("flt_rst_addr", {20'b0, imem_addr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("restart_valid", {31'b0, instr_valid}, 32'h1);
    chk("restart_pc", instr_pc, 32'h0);
    chk("restart_instr", instr, 32'h2008_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the 4096-word combinational instruction memory.
- Owns the program counter, drives the 12-bit word address, and registers the returned 32-bit word into a one-entry output stage with a valid/ready handshake toward decode.
- Accepts PC redirects from branch/jump resolution; flushes the output stage on each redirect.
- Flags misaligned redirect targets with a sticky fault state.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; must be word-aligned.
- ADDR_W, 12, instruction memory word-address width; imem_addr = pc[ADDR_W+1:2].

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_addr  output  ADDR_W  word address to instruction memory, combinational from pc
- imem_data  input  32  instruction word returned combinationally by memory for imem_addr
- instr  output  32  registered instruction for decode
- instr_pc  output  32  byte address of instr
- instr_valid  output  1  instr/instr_pc hold a valid, unconsumed instruction
- instr_ready  input  1  decode accepts instr this cycle when instr_valid=1
- redirect  input  1  one-cycle pulse: discard in-flight instruction, continue at redirect_pc
- redirect_pc  input  32  new byte-address target
- fault  output  1  sticky: misaligned redirect target seen

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values:
  - pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fault=0, state=RUN.
  - Reset asserted mid-operation clears everything immediately, with no clock needed.
- imem_addr is always pc[ADDR_W+1:2], including in FAULT and during reset (which gives RESET_PC[ADDR_W+1:2]).
- State machine has two states, RUN and FAULT. Per-cycle priority in RUN:
  1. redirect=1, redirect_pc[1:0]==0:
     - pc<=redirect_pc, instr_valid<=0.
     - instr/instr_pc hold their values, which are don't-care.
     - Any instruction in the stage is dropped, even if instr_ready=1 this cycle. Decode treats a same-cycle handshake as void.
  2. redirect=1, redirect_pc[1:0]!=0:
     - fault<=1, instr_valid<=0, state<=FAULT.
     - pc holds its value.
  3. Stage load condition (instr_valid==0 or instr_ready==1):
     - instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
  4. Otherwise (stall: instr_valid=1, instr_ready=0):
     - All registers hold.
     - imem_addr stays on the next PC; the stalled instruction is not re-fetched.
- Latency:
  - First instr_valid occurs one cycle after reset deasserts.
  - A redirect costs one bubble: instr_valid=0 in the cycle after the redirect; the target instruction is valid in the following cycle.
  - Sustained throughput is one instruction per cycle while instr_ready=1.
- FAULT state:
  - instr_valid held at 0, pc frozen, redirect and instr_ready ignored.
  - Exits only via reset.
- Arithmetic and wrap:
  - pc+4 is full 32-bit, modulo 2^32.
  - imem_addr wraps naturally modulo 2^ADDR_W words: pc=0x0000_3FFC fetches word 4095, next fetch is word 0 at pc=0x0000_4000.
  - instr_pc reports the full 32-bit pc.
- redirect held high for multiple cycles: each cycle re-applies it; instr_valid stays 0 until the cycle after redirect drops.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments by 1 on every cycle with instr_valid=1 and instr_ready=1 and redirect=0 (retired handshakes only); wraps 0xFFFF_FFFF to 0.
  - Frozen in FAULT.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000; instr_ready=1; release reset:
  - cycle 1: instr=0x20080001, instr_pc=0x0.
  - cycles 2 and 3: instr_pc=0x4 and 0x8; instr_valid continuous.
- Stall: instr_ready=0 for 3 cycles while instr_pc=0x4:
  - instr/instr_pc/imem_addr hold (imem_addr=2).
  - After ready returns, the next instr_pc is 0x8; nothing is skipped or duplicated.
- redirect=1, redirect_pc=0x40 while instr_valid=1, instr_ready=1:
  - next cycle instr_valid=0.
  - following cycle instr_pc=0x40, instr=mem[16].
- redirect_pc=0x42:
  - fault=1 and instr_valid=0 next cycle.
  - Later redirect to 0x0 is ignored.
  - reset clears fault, and fetch restarts at RESET_PC.
- pc forced via redirect to 0x3FF8, ready=1:
  - fetch sequence imem_addr 4094, 4095, 0; instr_pc 0x3FF8, 0x3FFC, 0x4000.
- Async reset pulse mid-cycle during streaming: outputs clear immediately without a clock edge.
  - With FETCH_PERF_COUNT_EN: fetch_count=0 after reset, and equals 10 after 10 accepted handshakes with one redirect-dropped handshake excluded.
